// File: rtl/sample_capture.sv
// Frame capture engine: averages DECIM consecutive ADC samples into one word
// and streams MEM_SIZE words per frame into an external memory.
module sample_capture #(
    parameter int NUM_BITS = 10,
    parameter int MEM_SIZE = 2048,
    parameter int DECIM    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_valid,
    input  logic [NUM_BITS-1:0]         sample_in,
    input  logic                        start,
    input  logic                        frame_ack,
    output logic                        mem_we,
    output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
    output logic [NUM_BITS-1:0]         mem_din,
    output logic                        busy,
    output logic                        frame_ready,
    output logic                        overrun
);

    localparam int AW    = $clog2(MEM_SIZE);
    localparam int LOG_D = $clog2(DECIM);
    localparam int CNT_W = (LOG_D > 0) ? LOG_D : 1;
    localparam int ACC_W = NUM_BITS + LOG_D;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READY
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [NUM_BITS-1:0] din_q, din_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                overrun_q, overrun_d;
    logic [ACC_W-1:0]    sum;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        addr_d    = we_q ? addr_q + AW'(1) : addr_q;
        last_d    = last_q;
        we_d      = 1'b0;
        din_d     = din_q;
        overrun_d = overrun_q;
        sum       = acc_q + ACC_W'(sample_in);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CAPTURE;
                    overrun_d = 1'b0;
                    acc_d     = '0;
                    cnt_d     = '0;
                    addr_d    = '0;
                    last_d    = 1'b0;
                end
            end
            CAPTURE: begin
                // Once the final word is issued, further samples belong to no frame.
                if (sample_valid && !last_q) begin
                    if (cnt_q == CNT_W'(DECIM - 1)) begin
                        we_d   = 1'b1;
                        din_d  = sum[ACC_W-1:LOG_D];
                        acc_d  = '0;
                        cnt_d  = '0;
                        last_d = (addr_d == AW'(MEM_SIZE - 1));
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (we_q && last_q) begin
                    state_d = READY;
                    acc_d   = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end
            end
            READY: begin
                if (sample_valid) overrun_d = 1'b1;
                if (frame_ack)    state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d == CAPTURE);
        ready_d = (state_d == READY);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            we_q      <= 1'b0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            we_q      <= we_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_din     = din_q;
    assign busy        = busy_q;
    assign frame_ready = ready_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 The block SHALL take parameter NUM_BITS, default 10, the sample width and memory word width.
REQ-002 The block SHALL take parameter MEM_SIZE, default 2048, the number of words per frame; a power of 2.
REQ-003 The block SHALL take parameter DECIM, default 4, the samples averaged per stored word; a power of 2, at least 1.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 sample_valid  input  1  one-cycle strobe qualifying sample_in.
REQ-007 sample_in  input  NUM_BITS  unsigned ADC sample.
REQ-008 start  input  1  pulse requesting capture of one frame.
REQ-009 frame_ack  input  1  consumer has finished with the stored frame.
REQ-010 mem_we  output  1  write strobe to the frame memory.
REQ-011 mem_addr  output  clog2(MEM_SIZE)  frame memory word address.
REQ-012 mem_din  output  NUM_BITS  word written to the frame memory.
REQ-013 busy  output  1  high while in CAPTURE.
REQ-014 frame_ready  output  1  a complete frame is in memory, held until acknowledged.
REQ-015 overrun  output  1  sticky: samples were dropped while in READY.

Function
REQ-016 The block SHALL implement FSM states IDLE, CAPTURE and READY.
REQ-017 IDLE -> CAPTURE on start; start SHALL be ignored in CAPTURE and READY.
REQ-018 CAPTURE:
  - The block SHALL accumulate sample_in on each sample_valid into an accumulator of NUM_BITS+log2(DECIM) bits.
  - A group-count tracks valid samples within the current group of DECIM.
  - Samples with sample_valid low SHALL be ignored.
REQ-019 On the sample_valid completing a group of DECIM:
  - The next cycle SHALL have mem_we=1 and mem_din=(accumulator including that sample)>>log2(DECIM), truncated, not rounded.
  - The accumulator and group count SHALL then clear.
REQ-020 For DECIM=1, mem_din SHALL equal the sample, written one cycle after its sample_valid.
REQ-021 mem_addr SHALL be 0 for the first write of a frame and increment by 1 after each write; it SHALL be valid in the same cycle as mem_we.
REQ-022 mem_we SHALL be a single-cycle pulse per stored word and SHALL never be asserted outside the write for a completed group.
REQ-023 The write of address MEM_SIZE-1 SHALL end the frame:
  - State goes to READY in the cycle after that write.
  - frame_ready=1 and busy=0 SHALL hold from that cycle.
  - mem_addr SHALL wrap to 0.
REQ-024 READY -> IDLE on frame_ack; frame_ready SHALL deassert in the next cycle; frame_ack SHALL be ignored in IDLE and CAPTURE.
REQ-025 start and frame_ack high in the same cycle in READY: the ack SHALL be taken and the start dropped; a new start is required from IDLE.
REQ-026 sample_valid in READY SHALL set overrun; samples in IDLE SHALL be discarded silently; start accepted from IDLE SHALL clear overrun.
REQ-027 busy SHALL be 1 exactly while the state is CAPTURE.
REQ-028 Total latency, start to frame_ready: the cycle after the write of the (MEM_SIZE*DECIM)-th valid sample after start.
REQ-029 A sample_valid in the cycle start is accepted SHALL NOT be captured; capture begins with the first sample_valid after entry to CAPTURE.

Reset
REQ-030 rst SHALL force state IDLE in any state and discard any partial frame and accumulator.
REQ-031 rst SHALL give mem_we=0, mem_addr=0, mem_din=0, busy=0, frame_ready=0 and overrun=0 on the clock edge where it is sampled high.
REQ-032 rst SHALL take priority over start, frame_ack and sample_valid in the same cycle.

Verification
REQ-033 The bench SHALL cover these scenarios:
  - MEM_SIZE=8, DECIM=4: start, then 32 valid samples of value 100, one per 3 cycles -> 8 writes at addr 0..7, mem_din=100, frame_ready the cycle after the addr-7 write.
  - DECIM=4, group values 1,2,3,5 (sum 11) -> mem_din=2 (truncation); group 1023 x4 -> mem_din=1023 (no overflow).
  - Frame completes, 3 sample_valid pulses in READY -> overrun=1, no mem_we; frame_ack -> IDLE; start -> overrun=0, first write at addr 0.
  - rst asserted after 5 words of a MEM_SIZE=8 frame -> all outputs 0 next cycle; start then gives first write at addr 0 with fresh accumulator.
  - start during CAPTURE and frame_ack during CAPTURE -> no effect on addr sequence; start+frame_ack together in READY -> IDLE, busy stays 0.
  - DECIM=1: sample_valid on every cycle with values 0..7 -> mem_we high 8 consecutive cycles, mem_din 0..7 each one cycle after its input.
